// File: rtl/pixel_feeder.sv
// Line-buffer fetch sequencer and pixel shifter: walks one scanline's words out of
// the line buffer and serialises them MSB-first at 1/2/4/8 bpp with horizontal zoom.
module pixel_feeder #(
   parameter int WORD_W = 16,
   parameter int ADR_W  = 9
) (
   input  logic              dotclk_i,
   input  logic              rst_ni,
   input  logic              scanline_en_i,
   input  logic [1:0]        bpp_i,
   input  logic [1:0]        hzoom_i,
   input  logic [ADR_W-1:0]  base_adr_i,
   input  logic [ADR_W-1:0]  words_i,
   input  logic [WORD_W-1:0] f_dat_i,
   output logic [ADR_W-1:0]  f_adr_o,
   output logic              f_en_o,
   output logic              load_o,
   output logic [7:0]        pix_o,
   output logic              pix_valid_o,
   output logic              eol_o
);

   localparam int PIX_W = $clog2(WORD_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_WAIT,
      S_RUN,
      S_DONE
   } state_e;

   state_e              state_q;
   logic [ADR_W-1:0]    f_adr_q;
   logic                f_en_q;
   logic                load_q;
   logic                pix_valid_q;
   logic                eol_q;
   logic [WORD_W-1:0]   shifter_q;
   logic [1:0]          hold_q;
   logic [PIX_W-1:0]    pix_q;
   logic [ADR_W-1:0]    words_left_q;
   logic [1:0]          bpp_q;
   logic [1:0]          hzoom_q;

   logic [WORD_W-1:0]   shifter_d;
   logic [ADR_W-1:0]    f_adr_d;
   logic [ADR_W-1:0]    words_left_d;
   logic [PIX_W-1:0]    pix_d;
   logic [PIX_W-1:0]    pix_last;
   logic [7:0]          pix_sel;

   // Mode-dependent shift step, last pixel index within a word, and the top-of-shifter pixel.
   always_comb begin
      shifter_d = shifter_q;
      pix_last  = '0;
      pix_sel   = '0;
      case (bpp_q)
         2'd0: begin
            shifter_d = shifter_q << 1;
            pix_last  = PIX_W'(WORD_W - 1);
            pix_sel   = {7'b0, shifter_q[WORD_W-1]};
         end
         2'd1: begin
            shifter_d = shifter_q << 2;
            pix_last  = PIX_W'(WORD_W / 2 - 1);
            pix_sel   = {6'b0, shifter_q[WORD_W-1 -: 2]};
         end
         2'd2: begin
            shifter_d = shifter_q << 4;
            pix_last  = PIX_W'(WORD_W / 4 - 1);
            pix_sel   = {4'b0, shifter_q[WORD_W-1 -: 4]};
         end
         default: begin
            shifter_d = shifter_q << 8;
            pix_last  = PIX_W'(WORD_W / 8 - 1);
            pix_sel   = shifter_q[WORD_W-1 -: 8];
         end
      endcase
   end

   assign f_adr_d      = f_adr_q + ADR_W'(1);
   assign words_left_d = words_left_q - ADR_W'(1);
   assign pix_d        = pix_q + PIX_W'(1);

   // Line sequencer. Dropping scanline_en_i overrides every state and parks at IDLE.
   always_ff @(posedge dotclk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         f_adr_q      <= '0;
         f_en_q       <= 1'b0;
         load_q       <= 1'b0;
         pix_valid_q  <= 1'b0;
         eol_q        <= 1'b0;
         shifter_q    <= '0;
         hold_q       <= '0;
         pix_q        <= '0;
         words_left_q <= '0;
         bpp_q        <= '0;
         hzoom_q      <= '0;
      end else if (!scanline_en_i) begin
         state_q     <= S_IDLE;
         f_adr_q     <= base_adr_i;
         f_en_q      <= 1'b0;
         load_q      <= 1'b0;
         pix_valid_q <= 1'b0;
         eol_q       <= 1'b0;
         shifter_q   <= '0;
         hold_q      <= '0;
         pix_q       <= '0;
      end else begin
         f_en_q <= 1'b0;
         load_q <= 1'b0;
         eol_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               bpp_q        <= bpp_i;
               hzoom_q      <= hzoom_i;
               words_left_q <= words_i;
               f_adr_q      <= base_adr_i;
               shifter_q    <= '0;
               hold_q       <= '0;
               pix_q        <= '0;
               if (words_i == '0) begin
                  state_q <= S_DONE;
                  eol_q   <= 1'b1;
               end else begin
                  state_q <= S_PRIME;
                  f_en_q  <= 1'b1;
               end
            end
            S_PRIME: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               shifter_q    <= f_dat_i;
               f_adr_q      <= f_adr_d;
               words_left_q <= words_left_d;
               load_q       <= 1'b1;
               pix_valid_q  <= 1'b1;
               f_en_q       <= (words_left_d != '0);
               hold_q       <= '0;
               pix_q        <= '0;
               state_q      <= S_RUN;
            end
            S_RUN: begin
               if (hold_q < hzoom_q) begin
                  hold_q <= hold_q + 2'd1;
               end else begin
                  hold_q <= '0;
                  if (pix_q != pix_last) begin
                     shifter_q <= shifter_d;
                     pix_q     <= pix_d;
                  end else if (words_left_q != '0) begin
                     // The word fetched after the previous load has been held on f_dat_i since.
                     shifter_q    <= f_dat_i;
                     f_adr_q      <= f_adr_d;
                     words_left_q <= words_left_d;
                     load_q       <= 1'b1;
                     f_en_q       <= (words_left_d != '0);
                     pix_q        <= '0;
                  end else begin
                     state_q     <= S_DONE;
                     pix_valid_q <= 1'b0;
                     eol_q       <= 1'b1;
                     shifter_q   <= '0;
                  end
               end
            end
            S_DONE: begin
               pix_valid_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign f_adr_o     = f_adr_q;
   assign f_en_o      = f_en_q;
   assign load_o      = load_q;
   assign pix_valid_o = pix_valid_q;
   assign eol_o       = eol_q;
   assign pix_o       = pix_valid_q ? pix_sel : 8'h00;

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed bench for pixel_feeder: a one-cycle-latency RAM model feeds the DUT and
// a pixel scoreboard built from that RAM is checked dot by dot.
module tb_pixel_feeder;

   logic        dotclk = 1'b0;
   logic        rst_n;
   logic        scanline_en;
   logic [1:0]  bpp;
   logic [1:0]  hzoom;
   logic [8:0]  base_adr;
   logic [8:0]  words;
   logic [15:0] f_dat = 16'h0000;
   logic [8:0]  f_adr;
   logic        f_en;
   logic        load;
   logic [7:0]  pix;
   logic        pix_valid;
   logic        eol;

   logic [15:0] ram [0:511];
   logic [7:0]  sbq [$];
   int          checks = 0;
   int          errors = 0;

   pixel_feeder #(.WORD_W(16), .ADR_W(9)) dut (
      .dotclk_i      (dotclk),
      .rst_ni        (rst_n),
      .scanline_en_i (scanline_en),
      .bpp_i         (bpp),
      .hzoom_i       (hzoom),
      .base_adr_i    (base_adr),
      .words_i       (words),
      .f_dat_i       (f_dat),
      .f_adr_o       (f_adr),
      .f_en_o        (f_en),
      .load_o        (load),
      .pix_o         (pix),
      .pix_valid_o   (pix_valid),
      .eol_o         (eol)
   );

   always #5 dotclk = ~dotclk;

   // Synchronous line buffer: data appears after the enabled edge and holds otherwise.
   always @(posedge dotclk) begin
      if (f_en) f_dat <= ram[f_adr];
   end

   task automatic tick();
      @(posedge dotclk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic [1:0] b, input logic [1:0] h,
                                input logic [8:0] ba, input logic [8:0] w);
      scanline_en = en;
      bpp         = b;
      hzoom       = h;
      base_adr    = ba;
      words       = w;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("[TB] check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_fen"},   32'(f_en),      32'd0);
      checkOutput({tag, "_load"},  32'(load),      32'd0);
      checkOutput({tag, "_pix"},   32'(pix),       32'd0);
      checkOutput({tag, "_valid"}, 32'(pix_valid), 32'd0);
      checkOutput({tag, "_eol"},   32'(eol),       32'd0);
   endtask

   // Runs one line from IDLE; abortDot >= 0 drops scanline_en at that dot and
   // also changes bpp_i mid-line to show the latched mode is kept.
   task automatic runLine(input logic [8:0] ba, input logic [8:0] w, input logic [1:0] b,
                          input logic [1:0] h, input int abortDot);
      int bits, perWord, dpw, total;
      logic [15:0] val;
      bits    = 1 << b;
      perWord = 16 / bits;
      dpw     = perWord * (int'(h) + 1);
      total   = int'(w) * dpw;
      sbq.delete();
      for (int k = 0; k < int'(w); k++) begin
         val = ram[9'(int'(ba) + k)];
         for (int p = 0; p < perWord; p++)
            for (int r = 0; r <= int'(h); r++)
               sbq.push_back(8'((int'(val) >> (16 - bits * (p + 1))) & ((1 << bits) - 1)));
      end
      applyStimulus(1'b1, b, h, ba, w);
      tick();
      checkOutput("e0_fen",   32'(f_en),      32'(w != 9'd0));
      checkOutput("e0_adr",   32'(f_adr),     32'(ba));
      checkOutput("e0_valid", 32'(pix_valid), 32'd0);
      checkOutput("e0_eol",   32'(eol),       32'(w == 9'd0));
      if (w == 9'd0) begin
         tick();
         checkQuiet("empty_after");
      end else begin
         tick();
         checkOutput("e1_fen",   32'(f_en),      32'd0);
         checkOutput("e1_valid", 32'(pix_valid), 32'd0);
         tick();
         for (int d = 0; d < total; d++) begin
            int widx;
            logic [7:0] e;
            widx = d / dpw;
            e = sbq.pop_front();
            checkOutput("valid",   32'(pix_valid), 32'd1);
            checkOutput("pix",     32'(pix),       32'(e));
            checkOutput("load",    32'(load),      32'((d % dpw) == 0));
            checkOutput("fen",     32'(f_en),      32'(((d % dpw) == 0) && (widx < int'(w) - 1)));
            checkOutput("fadr",    32'(f_adr),     32'(9'(int'(ba) + widx + 1)));
            checkOutput("eol_mid", 32'(eol),       32'd0);
            if (abortDot >= 0 && d == 2) begin
               bpp   = ~b;
               words = 9'd1;
            end
            if (d == abortDot) begin
               scanline_en = 1'b0;
               base_adr    = 9'h055;
               break;
            end
            tick();
         end
         if (abortDot >= 0) begin
            tick();
            checkQuiet("abort");
            checkOutput("abort_adr", 32'(f_adr), 32'h055);
            tick();
            checkQuiet("abort2");
         end else begin
            checkOutput("eol",       32'(eol),       32'd1);
            checkOutput("eol_valid", 32'(pix_valid), 32'd0);
            checkOutput("eol_pix",   32'(pix),       32'd0);
            checkOutput("eol_fen",   32'(f_en),      32'd0);
            tick();
            checkQuiet("done");
            checkOutput("done_adr", 32'(f_adr), 32'(9'(int'(ba) + int'(w))));
         end
      end
      if (abortDot < 0) begin
         scanline_en = 1'b0;
         tick();
         checkOutput("idle_adr", 32'(f_adr), 32'(base_adr));
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
      rst_n = 1'b0;
      applyStimulus(1'b0, 2'd0, 2'd0, 9'h000, 9'd0);
      #3;
      checkQuiet("reset");
      checkOutput("reset_adr", 32'(f_adr), 32'd0);
      #4;
      rst_n = 1'b1;
      tick();
      checkOutput("post_reset_adr", 32'(f_adr), 32'd0);

      $display("[TB] 1 bpp line");
      ram[9'h010] = 16'hA5F0;
      ram[9'h011] = 16'h0001;
      runLine(9'h010, 9'd2, 2'd0, 2'd0, -1);

      $display("[TB] 8 bpp line, zoom 4");
      ram[9'h020] = 16'h1234;
      ram[9'h021] = 16'h5678;
      ram[9'h022] = 16'h9ABC;
      runLine(9'h020, 9'd3, 2'd3, 2'd3, -1);

      $display("[TB] empty line");
      runLine(9'h030, 9'd0, 2'd0, 2'd0, -1);

      $display("[TB] address wrap, 4 bpp zoom 2");
      ram[9'h1FF] = 16'hC3A1;
      ram[9'h000] = 16'h0F0F;
      ram[9'h001] = 16'h8001;
      runLine(9'h1FF, 9'd3, 2'd2, 2'd1, -1);

      $display("[TB] abort at dot 5, 2 bpp");
      ram[9'h040] = 16'h1B6C;
      ram[9'h041] = 16'hE4E4;
      runLine(9'h040, 9'd2, 2'd1, 2'd0, 5);

      $display("[TB] reset mid-line");
      ram[9'h050] = 16'h8421;
      applyStimulus(1'b1, 2'd0, 2'd1, 9'h050, 9'd1);
      tick();
      tick();
      tick();
      tick();
      checkOutput("pre_rst_valid", 32'(pix_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkQuiet("mid_reset");
      checkOutput("mid_reset_adr", 32'(f_adr), 32'd0);
      #1;
      applyStimulus(1'b0, 2'd0, 2'd0, 9'h123, 9'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("rst_release_adr", 32'(f_adr), 32'h123);
      runLine(9'h050, 9'd1, 2'd0, 2'd1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pixel_feeder.md
# pixel_feeder

Parametrised successor to the scanline feeder. It generates line-buffer fetch addresses, owns the pixel shifter, and emits one pixel per dot clock in 1/2/4/8 bpp modes. It supports per-line base address, word count and horizontal zoom. It sits between the line buffer (synchronous RAM, one-cycle read latency) and the palette lookup.

## Interface
Parameters:
- WORD_W, 16, line-buffer word width in bits; power of two, ≥16.
- ADR_W, 9, line-buffer address width in bits.

Ports:
- dotclk_i  in  1  dot clock; all state changes on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- scanline_en_i  in  1  1 while a scanline is being refreshed.
- bpp_i  in  2  pixel depth: 00=1, 01=2, 10=4, 11=8 bpp.
- hzoom_i  in  2  each pixel is held for hzoom_i+1 dots.
- base_adr_i  in  ADR_W  first word address of the line.
- words_i  in  ADR_W  number of words to display on the line.
- f_dat_i  in  WORD_W  line-buffer read data; valid from the edge after f_en_o=1, and held while f_en_o=0.
- f_adr_o  out  ADR_W  line-buffer fetch address.
- f_en_o  out  1  line-buffer read enable.
- load_o  out  1  1-cycle strobe in the cycle after each shifter load.
- pix_o  out  8  current pixel, zero-extended; 0 when pix_valid_o=0.
- pix_valid_o  out  1  pix_o carries line data.
- eol_o  out  1  1-cycle pulse when the last pixel of the line has finished.

## Operation
- States: IDLE, PRIME, WAIT, RUN, DONE.
- **IDLE** (entered whenever scanline_en_i is sampled 0, from any state):
  - Next edge: f_adr_o<=base_adr_i.
  - f_en_o, load_o, pix_valid_o and eol_o are 0; the shifter, hold counter and pixel counter are cleared.
- **IDLE with scanline_en_i=1** (edge E0):
  - Latch bpp_i, hzoom_i and words_i into a line configuration; later input changes are ignored until the next IDLE.
  - words_left<=words_i.
  - If words_i==0: go to DONE and set eol_o<=1.
  - Otherwise: go to PRIME and set f_en_o<=1.
- **PRIME** (edge E1): RAM reads f_adr_o; f_en_o<=0; go to WAIT.
- **WAIT** (edge E2), which is a load:
  - shifter<=f_dat_i; f_adr_o<=f_adr_o+1.
  - words_left<=words_left−1; load_o<=1; pix_valid_o<=1.
  - f_en_o<=1 if words_left−1≠0.
  - Go to RUN.
- **RUN**, per edge:
  - If hold<hzoom: hold++.
  - Otherwise hold<=0, then:
    - If pix<P−1 (P=WORD_W/bpp): shifter<<=bpp and pix++.
    - If pix==P−1 and words_left≠0: load as in WAIT, pix<=0.
    - If pix==P−1 and words_left==0: go to DONE; pix_valid_o<=0, eol_o<=1, shifter<=0.
  - f_en_o and load_o are high only in the cycle after a load.
- **DONE**: all outputs 0, f_adr_o held, until scanline_en_i=0.
- Pixel order: MSB first. pix_o = shifter[WORD_W−1 -: bpp], gated by pix_valid_o.
- Arithmetic:
  - f_adr_o wraps modulo 2^ADR_W.
  - words_left is ADR_W bits; words_i=2^ADR_W−1 is legal.
- Counters: the hold counter is 2 bits; the pixel counter has width log2(WORD_W).
- Fetch slack:
  - Each word lasts P·(hzoom+1) ≥ 2 dots.
  - The fetch issued in the cycle after a load is therefore always complete before the next load.

## Timing
- Reset values: f_adr_o=0, f_en_o=0, load_o=0, pix_o=0, pix_valid_o=0, eol_o=0, state IDLE. Reset clears all outputs asynchronously.
- First pixel: visible in the cycle after E2, two edges after scanline_en_i is first sampled 1.
- Line length: pix_valid_o is high for exactly words_i·P·(hzoom+1) cycles.
- eol_o: asserts in the cycle immediately after the last dot.
- Dropping scanline_en_i mid-line: the next edge goes to IDLE with no eol_o and no further fetches.
- Re-asserting scanline_en_i in the same cycle as eol_o: no effect until the block passes through IDLE.
- Reset mid-line: outputs clear immediately; after release, the block restarts from IDLE.

## Test plan
- **Reset:** assert rst_ni=0 mid-RUN -> all outputs 0 without a clock edge; after release with scanline_en_i=0 -> f_adr_o=base_adr_i after one edge.
- **1 bpp line:** base=0x010, words=2, hzoom=0, RAM[0x010]=0xA5F0, RAM[0x011]=0x0001 ->
  - pix_o sequence 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0, then fifteen 0s and a final 1;
  - load_o at dots 0 and 16; f_en_o/f_adr_o=0x011 at dot 0 only;
  - 32 valid cycles; eol_o at dot 32.
- **8 bpp line with zoom:** hzoom=3, words=3, RAM words 0x1234, 0x5678, 0x9ABC ->
  - pixels 0x12,0x34,0x56,… each held 4 cycles;
  - load_o every 8 cycles; 24 valid cycles.
- **Empty line:** words_i=0 -> f_en_o never asserts; eol_o is high in the cycle after E0; pix_valid_o stays 0.
- **Address wrap:** base=0x1FF, words=3 -> fetch addresses 0x1FF, 0x000, 0x001.
- **Abort and config latch:** scanline_en_i drops at dot 5 of 2 bpp line; also bpp_i changes mid-line ->
  - the mode change has no effect;
  - after the drop: pix_valid_o=0 on the next edge, no eol_o, f_adr_o=base_adr_i.
